fir_param: RTL and testbench

FIR_PARAM -- requirements
Module: fir_param

---
 rtl/fir_param.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_fir_param.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_param.sv
// ---------------------------------------------------------------------------
// fir_param: multi-channel, time-multiplexed FIR filter.
//
// Each channel keeps its own circular history of NUM_TAPS samples; all
// channels share one coefficient set. Every accepted sample runs NUM_TAPS
// multiply-accumulate cycles on a single multiplier. The result is then
// rounded, scaled back to Q(DATA_W-1) and saturated. In bypass mode the
// accepted sample is passed straight through. Bypass samples still enter the
// history.
//
// Latency, counted from the accepting clock edge to the y_out_valid edge:
//   filtered : NUM_TAPS + 2 cycles
//   bypass   : 2 cycles
//
// Ports
//   clk          sole clock
//   reset        asynchronous, active-high reset
//   x_in         input sample, signed Q(DATA_W-1)
//   x_in_ch      channel of x_in
//   x_in_valid   sample offered
//   x_in_ready   high only in IDLE; accept = valid & ready
//   bypass       passthrough select, sampled at accept
//   coef_we      coefficient write strobe (honoured only in IDLE)
//   coef_addr    tap index k
//   coef_data    value for h[k], signed Q(COEF_W-1)
//   y_out        output sample, held between valid pulses
//   y_out_ch     channel of y_out
//   y_out_valid  one-cycle pulse per produced sample
// ---------------------------------------------------------------------------
module fir_param #(
   parameter int DATA_W   = 16,
   parameter int COEF_W   = 16,
   parameter int NUM_TAPS = 32,
   parameter int NUM_CH   = 2,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int TAP_W   = $clog2(NUM_TAPS),
   localparam int ACC_W   = DATA_W + COEF_W + TAP_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] x_in,
   input  logic [CH_W-1:0]   x_in_ch,
   input  logic              x_in_valid,
   output logic              x_in_ready,
   input  logic              bypass,
   input  logic              coef_we,
   input  logic [TAP_W-1:0]  coef_addr,
   input  logic [COEF_W-1:0] coef_data,
   output logic [DATA_W-1:0] y_out,
   output logic [CH_W-1:0]   y_out_ch,
   output logic              y_out_valid
);

   localparam int PROD_W = DATA_W + COEF_W;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MAC  = 2'd1;
   localparam logic [1:0] ST_OUT  = 2'd2;

   localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(NUM_TAPS - 1);

   // Saturation limits expressed at accumulator width.
   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

   // Half an LSB of the output scale, added before the truncating shift.
   localparam logic signed [ACC_W-1:0] ROUND = ACC_W'(1) << (COEF_W - 2);

   // Identity filter: h[0] = largest positive Q(COEF_W-1) value.
   localparam logic signed [COEF_W-1:0] H0_RESET = {1'b0, {(COEF_W - 1){1'b1}}};

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [1:0]               state_q, state_d;
   logic signed [DATA_W-1:0] dl_q [NUM_CH][NUM_TAPS];
   logic [TAP_W-1:0]         ptr_q [NUM_CH];
   logic signed [COEF_W-1:0] h_q [NUM_TAPS];

   logic signed [ACC_W-1:0]  acc_q;
   logic [TAP_W-1:0]         k_q;       // tap index of the current MAC
   logic [TAP_W-1:0]         rd_q;      // history slot holding x[n-k]
   logic [CH_W-1:0]          ch_q;      // channel of the sample in flight
   logic                     byp_q;
   logic signed [DATA_W-1:0] xh_q;      // accepted sample, for bypass

   // Result staging: one register stage between the end of the computation
   // and the visible output so y_out only ever changes with its valid pulse.
   logic [DATA_W-1:0]        res_q;
   logic [CH_W-1:0]          res_ch_q;
   logic                     res_pend_q;

   logic [DATA_W-1:0]        y_q;
   logic [CH_W-1:0]          y_ch_q;
   logic                     y_valid_q;

   // ------------------------------------------------------------------------
   // Handshake and write decode
   // ------------------------------------------------------------------------
   logic accept;
   logic ch_ok;
   logic take;
   logic coef_wr;
   logic mac_last;

   assign x_in_ready = (state_q == ST_IDLE);
   assign accept     = x_in_valid & x_in_ready;
   assign ch_ok      = int'(x_in_ch) < NUM_CH;
   // An accepted sample on a non-existent channel is swallowed silently.
   assign take       = accept & ch_ok;
   assign coef_wr    = coef_we & (state_q == ST_IDLE) & (int'(coef_addr) < NUM_TAPS);
   assign mac_last   = (k_q == TAP_LAST);

   // ------------------------------------------------------------------------
   // FSM next state
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (take) begin
               state_d = bypass ? ST_OUT : ST_MAC;
            end
         end
         ST_MAC: begin
            if (mac_last) begin
               state_d = ST_OUT;
            end
         end
         ST_OUT:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------------
   // Delay lines and write pointers
   // ------------------------------------------------------------------------
   logic [TAP_W-1:0] wr_ptr;
   logic [TAP_W-1:0] wr_ptr_nxt;

   always_comb begin
      wr_ptr     = ptr_q[x_in_ch];
      wr_ptr_nxt = (wr_ptr == TAP_LAST) ? '0 : wr_ptr + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < NUM_CH; c++) begin
            ptr_q[c] <= '0;
            for (int t = 0; t < NUM_TAPS; t++) begin
               dl_q[c][t] <= '0;
            end
         end
      end else if (take) begin
         dl_q[x_in_ch][wr_ptr] <= x_in;
         ptr_q[x_in_ch]        <= wr_ptr_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Coefficients. A write coinciding with an accept lands on the same edge,
   // and MAC reads start the following cycle, so the new value is used.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_q[0] <= H0_RESET;
         for (int t = 1; t < NUM_TAPS; t++) begin
            h_q[t] <= '0;
         end
      end else if (coef_wr) begin
         h_q[coef_addr] <= coef_data;
      end
   end

   // ------------------------------------------------------------------------
   // Multiply-accumulate datapath
   // ------------------------------------------------------------------------
   logic signed [DATA_W-1:0] tap_x;
   logic signed [COEF_W-1:0] tap_h;
   logic signed [PROD_W-1:0] x_ext;
   logic signed [PROD_W-1:0] h_ext;
   logic signed [PROD_W-1:0] prod;
   logic [TAP_W-1:0]         rd_nxt;

   always_comb begin
      tap_x  = dl_q[ch_q][rd_q];
      tap_h  = h_q[k_q];
      x_ext  = PROD_W'(tap_x);
      h_ext  = PROD_W'(tap_h);
      prod   = x_ext * h_ext;
      // Walk backwards through history: x[n], x[n-1], ...
      rd_nxt = (rd_q == '0) ? TAP_LAST : rd_q - 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q <= '0;
         k_q   <= '0;
         rd_q  <= '0;
         ch_q  <= '0;
         byp_q <= 1'b0;
         xh_q  <= '0;
      end else begin
         if (state_q == ST_IDLE && take) begin
            // Newest sample sits at the slot just written.
            acc_q <= '0;
            k_q   <= '0;
            rd_q  <= wr_ptr;
            ch_q  <= x_in_ch;
            byp_q <= bypass;
            xh_q  <= x_in;
         end else if (state_q == ST_MAC) begin
            acc_q <= acc_q + ACC_W'(prod);
            k_q   <= k_q + 1'b1;
            rd_q  <= rd_nxt;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Rounding, scaling and saturation
   // ------------------------------------------------------------------------
   logic signed [ACC_W-1:0] acc_rnd;
   logic signed [ACC_W-1:0] acc_shf;
   logic [DATA_W-1:0]       sat_val;

   always_comb begin
      acc_rnd = acc_q + ROUND;
      acc_shf = acc_rnd >>> (COEF_W - 1);
      if (acc_shf > SAT_MAX) begin
         sat_val = SAT_MAX[DATA_W-1:0];
      end else if (acc_shf < SAT_MIN) begin
         sat_val = SAT_MIN[DATA_W-1:0];
      end else begin
         sat_val = acc_shf[DATA_W-1:0];
      end
   end

   // ------------------------------------------------------------------------
   // Result staging and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_q      <= '0;
         res_ch_q   <= '0;
         res_pend_q <= 1'b0;
      end else if (state_q == ST_OUT) begin
         res_q      <= byp_q ? xh_q : sat_val;
         res_ch_q   <= ch_q;
         res_pend_q <= 1'b1;
      end else begin
         res_pend_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         y_q       <= '0;
         y_ch_q    <= '0;
         y_valid_q <= 1'b0;
      end else begin
         y_valid_q <= res_pend_q;
         if (res_pend_q) begin
            y_q    <= res_q;
            y_ch_q <= res_ch_q;
         end
      end
   end

   assign y_out       = y_q;
   assign y_out_ch    = y_ch_q;
   assign y_out_valid = y_valid_q;

endmodule

// File: tb/tb_fir_param.sv
// ---------------------------------------------------------------------------
// tb_fir_param: directed, self-checking bench for fir_param with default
// parameters (16-bit data and coefficients, 32 taps, 2 channels).
// ---------------------------------------------------------------------------
module tb_fir_param;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] x_in = '0;
   logic        x_in_ch = 1'b0;
   logic        x_in_valid = 1'b0;
   logic        x_in_ready;
   logic        bypass = 1'b0;
   logic        coef_we = 1'b0;
   logic [4:0]  coef_addr = '0;
   logic [15:0] coef_data = '0;
   logic [15:0] y_out;
   logic        y_out_ch;
   logic        y_out_valid;

   int total = 0;
   int bad   = 0;

   fir_param #(
      .DATA_W   (16),
      .COEF_W   (16),
      .NUM_TAPS (32),
      .NUM_CH   (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .x_in        (x_in),
      .x_in_ch     (x_in_ch),
      .x_in_valid  (x_in_valid),
      .x_in_ready  (x_in_ready),
      .bypass      (bypass),
      .coef_we     (coef_we),
      .coef_addr   (coef_addr),
      .coef_data   (coef_data),
      .y_out       (y_out),
      .y_out_ch    (y_out_ch),
      .y_out_valid (y_out_valid)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------- stimulus
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      x_in_valid = 1'b0;
      coef_we = 1'b0;
      bypass = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic load_coef(input int k, input int v);
      @(negedge clk);
      coef_we   = 1'b1;
      coef_addr = 5'(k);
      coef_data = 16'(v);
      @(negedge clk);
      coef_we = 1'b0;
   endtask

   // Offer one sample; returns just after the accepting edge.
   task automatic send(input int x, input logic ch, input logic byp);
      int n = 0;
      @(negedge clk);
      while (!x_in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      x_in       = 16'(x);
      x_in_ch    = ch;
      bypass     = byp;
      x_in_valid = 1'b1;
      @(posedge clk);
      #1;
      x_in_valid = 1'b0;
      bypass     = 1'b0;
   endtask

   // Count edges from the accept edge to y_out_valid; lat = -1 on timeout.
   task automatic get_out(output logic [15:0] y, output logic ych, output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!y_out_valid && lat < 100);
      y   = y_out;
      ych = y_out_ch;
      if (!y_out_valid) lat = -1;
   endtask

   task automatic xfer(input int x, input logic ch, input logic byp,
                       output logic [15:0] y, output logic ych, output int lat);
      send(x, ch, byp);
      get_out(y, ych, lat);
   endtask

   // ------------------------------------------------------------------- tests
   task automatic test_reset();
      logic [15:0] y;
      logic        ych;
      int          lat;
      @(negedge clk);
      reset = 1'b1;
      #2;
      total++;
      if (y_out !== 16'd0 || y_out_ch !== 1'b0 || y_out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs: got y=%0d ch=%0d v=%0d, want 0 0 0",
                  y_out, y_out_ch, y_out_valid);
      end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (x_in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready: got %0d, want 1", x_in_ready);
      end
      xfer(16384, 1'b0, 1'b0, y, ych, lat);
      total++;
      if (y !== 16'd16384 || ych !== 1'b0) begin
         bad++;
         $display("FAIL identity: got y=%0d ch=%0d, want 16384 0", $signed(y), ych);
      end
      total++;
      if (lat !== 34) begin
         bad++;
         $display("FAIL identity_latency: got %0d, want 34", lat);
      end
      // Pulse is one cycle wide and the value holds afterwards.
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (y_out_valid !== 1'b0 || y_out !== 16'd16384) begin
         bad++;
         $display("FAIL hold: got v=%0d y=%0d, want 0 16384", y_out_valid, $signed(y_out));
      end
   endtask

   task automatic test_impulse();
      logic [15:0] y;
      logic        ych;
      int          lat;
      do_reset();
      for (int k = 0; k < 32; k++) load_coef(k, 100 * (k + 1));
      for (int m = 0; m < 33; m++) begin
         xfer((m == 0) ? 16384 : 0, 1'b1, 1'b0, y, ych, lat);
         total++;
         if (y !== 16'((m < 32) ? 50 * (m + 1) : 0) || ych !== 1'b1) begin
            bad++;
            $display("FAIL impulse[%0d]: got y=%0d ch=%0d, want %0d 1", m, $signed(y), ych,
                     (m < 32) ? 50 * (m + 1) : 0);
         end
      end
   endtask

   task automatic test_isolation();
      logic [15:0] y;
      logic        ych;
      int          lat;
      do_reset();
      for (int k = 0; k < 32; k++) load_coef(k, 1024);
      for (int i = 1; i <= 32; i++) begin
         xfer(16384, 1'b0, 1'b0, y, ych, lat);
         total++;
         if (y !== 16'(512 * i) || ych !== 1'b0) begin
            bad++;
            $display("FAIL iso_ch0[%0d]: got y=%0d ch=%0d, want %0d 0", i, $signed(y), ych,
                     512 * i);
         end
         xfer(0, 1'b1, 1'b0, y, ych, lat);
         total++;
         if (y !== 16'd0 || ych !== 1'b1) begin
            bad++;
            $display("FAIL iso_ch1[%0d]: got y=%0d ch=%0d, want 0 1", i, $signed(y), ych);
         end
      end
   endtask

   task automatic test_saturation();
      logic [15:0] y;
      logic        ych;
      int          lat;
      do_reset();
      for (int k = 0; k < 32; k++) load_coef(k, 32767);
      for (int i = 0; i < 32; i++) begin
         xfer(32767, 1'b0, 1'b0, y, ych, lat);
         if (i == 0) begin
            total++;
            if (y !== 16'd32766) begin
               bad++;
               $display("FAIL sat_first: got %0d, want 32766", $signed(y));
            end
         end
      end
      total++;
      if (y !== 16'd32767) begin
         bad++;
         $display("FAIL sat_pos: got %0d, want 32767", $signed(y));
      end
      for (int i = 0; i < 32; i++) xfer(-32768, 1'b0, 1'b0, y, ych, lat);
      total++;
      if (y !== 16'h8000) begin
         bad++;
         $display("FAIL sat_neg: got %0d, want -32768", $signed(y));
      end
   endtask

   task automatic test_bypass_blocked();
      logic [15:0] y;
      logic        ych;
      int          lat;
      do_reset();
      xfer(-5, 1'b1, 1'b1, y, ych, lat);
      total++;
      if (y !== 16'hFFFB || ych !== 1'b1) begin
         bad++;
         $display("FAIL bypass: got y=%0d ch=%0d, want -5 1", $signed(y), ych);
      end
      total++;
      if (lat !== 2) begin
         bad++;
         $display("FAIL bypass_latency: got %0d, want 2", lat);
      end
      // Impulse on ch0 while trying to set h[1] during the MAC phase.
      send(16384, 1'b0, 1'b0);
      fork
         begin
            repeat (3) @(negedge clk);
            coef_we   = 1'b1;
            coef_addr = 5'd1;
            coef_data = 16'd5000;
            repeat (10) @(negedge clk);
            coef_we = 1'b0;
         end
         get_out(y, ych, lat);
      join
      total++;
      if (y !== 16'd16384) begin
         bad++;
         $display("FAIL blocked_first: got %0d, want 16384", $signed(y));
      end
      xfer(0, 1'b0, 1'b0, y, ych, lat);
      total++;
      if (y !== 16'd0) begin
         bad++;
         $display("FAIL blocked_write: got %0d, want 0", $signed(y));
      end
   endtask

   task automatic test_write_with_accept();
      logic [15:0] y;
      logic        ych;
      int          lat;
      do_reset();
      @(negedge clk);
      coef_we    = 1'b1;
      coef_addr  = 5'd0;
      coef_data  = 16'd16384;
      x_in       = 16'd16384;
      x_in_ch    = 1'b0;
      x_in_valid = 1'b1;
      @(posedge clk);
      #1;
      x_in_valid = 1'b0;
      coef_we    = 1'b0;
      get_out(y, ych, lat);
      total++;
      if (y !== 16'd8192) begin
         bad++;
         $display("FAIL write_first: got %0d, want 8192", $signed(y));
      end
   endtask

   task automatic test_reset_mid_mac();
      logic [15:0] y;
      logic        ych;
      int          lat;
      int          pulses = 0;
      do_reset();
      send(1000, 1'b0, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (y_out_valid) pulses++;
      end
      total++;
      if (pulses !== 0) begin
         bad++;
         $display("FAIL mid_mac_abort: got %0d pulses, want 0", pulses);
      end
      xfer(16384, 1'b0, 1'b0, y, ych, lat);
      total++;
      if (y !== 16'd16384 || lat !== 34) begin
         bad++;
         $display("FAIL after_abort: got y=%0d lat=%0d, want 16384 34", $signed(y), lat);
      end
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_isolation();
      test_saturation();
      test_bypass_blocked();
      test_write_with_accept();
      test_reset_mid_mac();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
